// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/subtract unit with start/done handshake.
// Processes DIGIT bits per clock over WIDTH-bit operands, LSB digit first.
// Optional feature: define ADDSUB_SAT_EN to get unsigned saturation of the
// final result; without it the result wraps modulo 2^WIDTH.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             enable,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  // Captured operation
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             opMode;

  // Serial datapath state: carry chain, digit index, partial result
  logic             chain;
  logic [CNT_W-1:0] digitCnt;
  logic [WIDTH-1:0] accum;

  // Visible result and flags, updated only on entry to DONE
  logic [WIDTH-1:0] resultReg;
  logic             coutReg;
  logic             zeroReg;
  logic             negReg;
  logic             ovfReg;

  // Combinational slice arithmetic
  logic [DIGIT-1:0] aSlice;
  logic [DIGIT-1:0] bSlice;
  logic [DIGIT:0]   sliceSum;
  logic             msbCarryIn;
  logic [WIDTH-1:0] accumNext;
  logic [WIDTH-1:0] finalRes;
  logic             rawCout;
  logic             lastDigit;
  logic             accept;

  assign accept    = start && (state != RUN);
  assign lastDigit = (digitCnt == LAST_DIGIT);

  // Add the current digit: subtraction is a + ~b + ~borrow, so only b inverts.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    aSlice     = opA[digitCnt*DIGIT +: DIGIT];
    bSlice     = opMode ? ~opB[digitCnt*DIGIT +: DIGIT] : opB[digitCnt*DIGIT +: DIGIT];
    sliceSum   = {1'b0, aSlice} + {1'b0, bSlice} + {{DIGIT{1'b0}}, chain};
    // Carry into the slice MSB recovered from its sum bit and operand bits
    msbCarryIn = sliceSum[DIGIT-1] ^ aSlice[DIGIT-1] ^ bSlice[DIGIT-1];
    accumNext  = accum;
    accumNext[digitCnt*DIGIT +: DIGIT] = sliceSum[DIGIT-1:0];
  end

  // The chain holds carry for add and inverted borrow for subtract
  assign rawCout = opMode ? ~sliceSum[DIGIT] : sliceSum[DIGIT];

`ifdef ADDSUB_SAT_EN
  // Clamp to the unsigned range: overflow pins high, underflow pins to zero
  assign finalRes = rawCout ? (opMode ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : accumNext;
`else
  assign finalRes = accumNext;
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: run N digits, then one DONE cycle (or straight into RUN)
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (lastDigit) nextState = DONE;
      DONE:    nextState = start ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, per-digit accumulation and final flag update
  // NOTE: every datapath register is reset here, including the captured
  // operands, so outputs are deterministic straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opA       <= '0;
      opB       <= '0;
      opMode    <= 1'b0;
      chain     <= 1'b0;
      digitCnt  <= '0;
      accum     <= '0;
      resultReg <= '0;
      coutReg   <= 1'b0;
      zeroReg   <= 1'b1;
      negReg    <= 1'b0;
      ovfReg    <= 1'b0;
    end else if (accept) begin
      opA      <= a;
      opB      <= b;
      opMode   <= mode;
      chain    <= cin ^ mode;
      digitCnt <= '0;
    end else if (state == RUN) begin
      accum    <= accumNext;
      chain    <= sliceSum[DIGIT];
      digitCnt <= digitCnt + CNT_W'(1);
      if (lastDigit) begin
        resultReg <= finalRes;
        coutReg   <= rawCout;
        zeroReg   <= (finalRes == {WIDTH{1'b0}});
        negReg    <= finalRes[WIDTH-1];
        ovfReg    <= msbCarryIn ^ sliceSum[DIGIT];
      end
    end
  end

  assign ready  = (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = resultReg & {WIDTH{enable}};
  assign cout   = coutReg;
  assign zero   = zeroReg;
  assign neg    = negReg;
  assign ovf    = ovfReg;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=8, DIGIT=2).
// Expected values come from a full-width arithmetic model pushed to a
// scoreboard at each accepted start; ADDSUB_SAT_EN selects saturating model.
module tb_addsub_serial;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NUM_DIGITS = WIDTH / DIGIT;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             enable;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
  } expT;

  expT sbq[$];
  int  checks   = 0;
  int  failures = 0;

  addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .enable (enable),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .neg    (neg),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout observed=stalled expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  function automatic expT model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic tm, input logic tc);
    logic [WIDTH:0] full;
    expT e;
    if (!tm) full = {1'b0, ta} + {1'b0, tb} + (WIDTH+1)'(tc);
    else     full = {1'b0, ta} - {1'b0, tb} - (WIDTH+1)'(tc);
    e.cout = full[WIDTH];
    e.res  = full[WIDTH-1:0];
    if (!tm) e.ovf = (ta[WIDTH-1] == tb[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
    else     e.ovf = (ta[WIDTH-1] != tb[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    if (e.cout) e.res = tm ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
`endif
    e.zero = (e.res == '0);
    e.neg  = e.res[WIDTH-1];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, hold it across the accepting edge, return at the
  // following falling edge (zero RUN edges consumed so far).
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tm, input logic tc, input bit keepStart);
    @(negedge clk);
    check("ready_before_start", 32'(ready), 32'd1);
    a = ta; b = tb; mode = tm; cin = tc; start = 1'b1;
    sbq.push_back(model(ta, tb, tm, tc));
    @(posedge clk);
    @(negedge clk);
    if (!keepStart) start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Count rising edges until done is seen, then compare with the scoreboard
  task automatic waitDone(input int expLat, input string tag);
    int  lat;
    bit  seen;
    expT e;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(expLat));
      check({tag, "_sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check({tag, "_result"}, 32'(result), 32'(e.res & {WIDTH{enable}}));
        check({tag, "_cout"},   32'(cout),   32'(e.cout));
        check({tag, "_zero"},   32'(zero),   32'(e.zero));
        check({tag, "_neg"},    32'(neg),    32'(e.neg));
        check({tag, "_ovf"},    32'(ovf),    32'(e.ovf));
      end
      check({tag, "_ready"}, 32'(ready), 32'd1);
      check({tag, "_busy"},  32'(busy),  32'd0);
    end
  endtask

  initial begin
    int donePulses;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rm;
    logic rc;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout",   32'(cout),   32'd0);
    check("rst_zero",   32'(zero),   32'd1);
    check("rst_neg",    32'(neg),    32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    rst_n = 1'b1;

    // Directed arithmetic cases
    issue(8'h50, 8'h30, 1'b1, 1'b0, 1'b0);
    waitDone(NUM_DIGITS, "sub_50_30");
    issue(8'h30, 8'h50, 1'b1, 1'b0, 1'b0);
    waitDone(NUM_DIGITS, "sub_30_50");
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    waitDone(NUM_DIGITS, "add_ff_01");
    issue(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    waitDone(NUM_DIGITS, "sub_80_01");
    issue(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
    waitDone(NUM_DIGITS, "add_7f_01_c");
    issue(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    waitDone(NUM_DIGITS, "sub_00_00_b");

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rm = 1'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rm, rc, 1'b0);
      waitDone(NUM_DIGITS, "random");
    end

    // start pulse plus operand change during RUN must be ignored
    issue(8'h50, 8'h30, 1'b1, 1'b0, 1'b0);
    check("run_ready_low", 32'(ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22; mode = 1'b0; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitDone(NUM_DIGITS - 2, "start_in_run");
    donePulses = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (done) donePulses++;
    end
    check("start_in_run_no_extra_done", 32'(donePulses), 32'd0);
    check("start_in_run_sb_empty", 32'(sbq.size()), 32'd0);

    // Back-to-back: start held high, second op accepted in DONE
    issue(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
    a = 8'hA0; b = 8'h0F; mode = 1'b1; cin = 1'b1;
    waitDone(NUM_DIGITS, "b2b_first");
    sbq.push_back(model(8'hA0, 8'h0F, 1'b1, 1'b1));
    @(posedge clk);
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(done), 32'd0);
    check("b2b_second_busy",    32'(busy), 32'd1);
    start = 1'b0;
    waitDone(NUM_DIGITS, "b2b_second");
    @(posedge clk);
    @(negedge clk);
    check("b2b_done_single_pulse", 32'(done), 32'd0);

    // Reset during RUN cycle 2 aborts with no done pulse
    issue(8'h50, 8'h30, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready",  32'(ready),  32'd1);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_zero",   32'(zero),   32'd1);
    sbq.delete();
    donePulses = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (done) donePulses++;
    end
    check("abort_no_done", 32'(donePulses), 32'd0);

    // enable gates result only; flags reflect the ungated value
    enable = 1'b0;
    issue(8'h50, 8'h30, 1'b1, 1'b0, 1'b0);
    waitDone(NUM_DIGITS, "gated");
    enable = 1'b1;
    #1;
    check("ungated_result", 32'(result), 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial add/subtract unit; the next generation of the team's 8-bit ripple subtractor.
- Processes DIGIT bits per clock over WIDTH-bit operands and supports add or subtract mode with a carry/borrow chain input.
- Produces a result plus carry/borrow, zero, negative and signed-overflow flags, with a start/done handshake.
- Serves as the shared ALU arithmetic path of the CPU datapath and trades latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin).
- a  input  WIDTH  minuend/augend; sampled at the accepting edge.
- b  input  WIDTH  subtrahend/addend; sampled at the accepting edge.
- cin  input  1  carry-in (add) or borrow-in (sub); sampled at the accepting edge.
- enable  input  1  output gate; result = internal result & {WIDTH{enable}}.
- ready  output  1  high in IDLE or DONE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  gated result, held until the next accepted start.
- cout  output  1  add: carry out; sub: borrow out (1 = a < b+cin, unsigned).
- zero  output  1  internal result == 0, after saturation if enabled; not gated by enable.
- neg  output  1  internal result MSB.
- ovf  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; internal result and digit counter cleared; ready=1, busy=0, done=0, result=0, cout=0, zero=1, neg=0, ovf=0.
- Reset has priority over everything. Reset mid-RUN aborts the operation with no done pulse.
- States are IDLE, RUN and DONE. N = WIDTH/DIGIT.
- IDLE or DONE with start=1:
  - capture a, b, mode and cin;
  - load the internal chain bit = cin for add, ~cin for sub;
  - counter=0; go to RUN.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN, each cycle, for digit k = counter (LSB first):
  - sum slice [k*DIGIT +: DIGIT] = a_slice + (mode ? ~b_slice : b_slice) + chain;
  - the slice is written into the internal result; chain takes the slice carry;
  - counter increments.
- After the last digit (counter = N-1): go to DONE.
  - Flags update at that same edge: cout = mode ? ~chain : chain; ovf from the MSB carry-in xor carry-out; neg, zero from the final result.
- Latency: done=1 and result valid in the cycle following the N-th edge after the accepting edge. DIGIT=WIDTH gives a 1-cycle RUN.
- start during RUN is ignored and not queued. Operand changes during RUN have no effect, since operands are captured.
- Back-to-back: start in DONE is accepted. done pulses for that cycle only; the next operation begins.
- result and flags are held from DONE until the next DONE. Partial digits are written only to the internal register, never to result, until DONE.
- enable affects result only, combinationally; flags and handshake are unaffected.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: unsigned saturation applied when entering DONE.
  - Add with cout=1: result = all ones.
  - Sub with borrow (cout=1): result = 0.
  - cout still reports the raw carry/borrow; zero and neg reflect the saturated value; ovf is unchanged (raw signed).
- Undefined: wrap-around modulo 2^WIDTH; no saturation logic synthesised.

Test Plan:
- WIDTH=8, DIGIT=2, mode=1, a=0x50, b=0x30, cin=0, enable=1 -> done 4 cycles after accept; result=0x20, cout=0, zero=0, neg=0, ovf=0.
- mode=1, a=0x30, b=0x50 -> result=0xE0, cout=1, neg=1. With ADDSUB_SAT_EN: result=0x00, zero=1, cout=1.
- mode=0, a=0xFF, b=0x01, cin=0 -> result=0x00, cout=1, zero=1. With ADDSUB_SAT_EN: result=0xFF, zero=0.
- mode=1, a=0x80, b=0x01 -> result=0x7F, ovf=1, cout=0. Then mode=0, a=0x7F, b=0x01, cin=1 -> result=0x81, ovf=1, neg=1.
- start pulsed during RUN and operands changed -> ignored; original result delivered. start held high in DONE -> second op accepted back-to-back; exactly one done pulse per op.
- rst_n=0 at RUN cycle 2 -> next cycle IDLE, ready=1, result=0, no done. Also: enable=0 -> result=0 while zero/cout match the ungated value.
